// File: rtl/parse_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// parse_seq_pkg
// Shared types and constants for the parse sequencer: FSM state encoding,
// parser status bit positions, host error codes, event kind tags and the
// event word layout used by the event FIFO and the downstream AST builder.
// No ports (package).
// -----------------------------------------------------------------------------
package parse_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_INIT    = 3'd1,
      ST_FETCH   = 3'd2,
      ST_PRESENT = 3'd3,
      ST_CHECK   = 3'd4,
      ST_DONE    = 3'd5,
      ST_FAIL    = 3'd6
   } seq_state_t;

   // Bit positions inside the parser status word {running, accept, error}
   localparam int STAT_RUN = 2;
   localparam int STAT_ACC = 1;
   localparam int STAT_ERR = 0;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_SYNTAX   = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
   localparam logic [1:0] ERR_OVERFLOW = 2'd3;

   localparam logic EVT_SHIFT  = 1'b0;
   localparam logic EVT_REDUCE = 1'b1;

   // Token kind byte that marks end of input
   localparam logic [7:0] TOK_EOF_KIND = 8'h00;

   localparam int EVT_W = 17;
   typedef logic [EVT_W-1:0] evt_t;

   // Event word: {kind, payload16}
   function automatic evt_t make_event(input logic kind, input logic [15:0] payload);
      return {kind, payload};
   endfunction

endpackage

// File: rtl/parse_sequencer_if.sv
// -----------------------------------------------------------------------------
// parse_sequencer_if
// Bundles the three streams around the sequencer:
//   t_*  lexer token stream      (t_valid/t_data in, t_ready out)
//   p_*  LR parser core          (reset, token handshake, status, outputs)
//   e_*  event stream to the AST builder (FWFT: e_valid/e_data out, e_ready in)
// master = sequencer side, slave = environment side (lexer/parser/consumer).
// -----------------------------------------------------------------------------
interface parse_sequencer_if;

   logic                  t_valid;
   logic [15:0]           t_data;
   logic                  t_ready;

   logic                  p_rst;
   logic                  p_i_valid;
   logic [15:0]           p_i_token;
   logic                  p_receive;
   logic [2:0]            p_stat;
   logic                  p_o_valid;
   logic [15:0]           p_o_shift;
   logic [15:0]           p_o_reduce;

   logic                  e_valid;
   parse_seq_pkg::evt_t   e_data;
   logic                  e_ready;

   modport master (
      input  t_valid, t_data,
      output t_ready,
      output p_rst, p_i_valid, p_i_token,
      input  p_receive, p_stat, p_o_valid, p_o_shift, p_o_reduce,
      output e_valid, e_data,
      input  e_ready
   );

   modport slave (
      output t_valid, t_data,
      input  t_ready,
      input  p_rst, p_i_valid, p_i_token,
      output p_receive, p_stat, p_o_valid, p_o_shift, p_o_reduce,
      input  e_valid, e_data,
      output e_ready
   );

endinterface

// File: rtl/parse_sequencer_evt_fifo.sv
// -----------------------------------------------------------------------------
// evt_fifo
// Synchronous first-word-fall-through FIFO for parser events.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_flush        : empties the FIFO (wins over push/pop)
//   i_push, i_data : write request and word
//   i_pop          : read request (ignored when empty)
//   o_data         : head word (valid while !o_empty)
//   o_empty/o_full : occupancy flags
//   o_drop         : push rejected this cycle because the FIFO is full
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module evt_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 16
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic             o_full,
   output logic             o_drop
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   // Pointers carry one extra wrap bit to tell full from empty
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = i_pop && !w_empty;
   assign w_push  = i_push && (!w_full || w_pop);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
   assign o_empty = w_empty;
   assign o_full  = w_full;
   assign o_drop  = i_push && !w_push && !i_flush;

endmodule

// File: rtl/parse_sequencer.sv
// -----------------------------------------------------------------------------
// parse_sequencer
// Runs one parse job on the LR parser core: holds the parser in reset while
// its tables load, feeds lexer tokens one at a time over the parser's
// valid/receive handshake, tags parser outputs as shift/reduce events into a
// FWFT FIFO, and reports the job outcome.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_start        : job start pulse (honoured in IDLE/DONE/FAIL only)
//   o_busy         : job in progress
//   o_done/o_fail  : job outcome levels
//   o_err_code     : 0 none, 1 syntax, 2 timeout, 3 event overflow
//   o_tok_count    : tokens consumed this job (saturating)
//   io_bus         : lexer, parser and event streams (master side)
// -----------------------------------------------------------------------------
module parse_sequencer
   import parse_seq_pkg::*;
#(
   parameter int INIT_CYCLES = 4,
   parameter int TIMEOUT     = 1024,
   parameter int EVT_DEPTH   = 16
)(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_fail,
   output logic [1:0]        o_err_code,
   output logic [15:0]       o_tok_count,
   parse_sequencer_if.master io_bus
);

   localparam int ICW = $clog2(INIT_CYCLES + 1);
   localparam int WDW = $clog2(TIMEOUT + 1);
   localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);

   seq_state_t     r_state;
   seq_state_t     w_state_next;
   logic [ICW-1:0] r_init_cnt;
   logic [WDW-1:0] r_wd;
   logic [15:0]    r_tok;
   logic           r_p_i_valid;
   logic [15:0]    r_tok_count;
   logic [1:0]     r_err_code;
   logic           r_recv_d;

   logic       w_busy;
   logic       w_start_job;
   logic       w_take_tok;
   logic       w_tok_recv;
   logic       w_err_load;
   logic [1:0] w_err_val;
   evt_t       w_evt;
   evt_t       w_evt_head;
   logic       w_fifo_empty;
   logic       w_fifo_full;
   logic       w_fifo_drop;
   logic       w_unused;

   assign w_busy = (r_state == ST_INIT) || (r_state == ST_FETCH) ||
                   (r_state == ST_PRESENT) || (r_state == ST_CHECK);

   // ---------------- state register ----------------
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_next;
   end

   // ---------------- next state / control ----------------
   always_comb begin
      w_state_next = r_state;
      w_start_job  = 1'b0;
      w_take_tok   = 1'b0;
      w_tok_recv   = 1'b0;
      w_err_load   = 1'b0;
      w_err_val    = ERR_NONE;
      case (r_state)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (i_start) begin
               w_state_next = ST_INIT;
               w_start_job  = 1'b1;
            end
         end
         ST_INIT: begin
            if (r_init_cnt == INIT_LAST) w_state_next = ST_FETCH;
         end
         ST_FETCH: begin
            if (io_bus.t_valid) begin
               w_state_next = ST_PRESENT;
               w_take_tok   = 1'b1;
            end
         end
         ST_PRESENT: begin
            // A receive in the last watchdog cycle still counts as on time
            if (io_bus.p_receive) begin
               w_state_next = ST_CHECK;
               w_tok_recv   = 1'b1;
            end else if (r_wd == WDW'(1)) begin
               w_state_next = ST_FAIL;
               w_err_load   = 1'b1;
               w_err_val    = ERR_TIMEOUT;
            end
         end
         ST_CHECK: begin
            if (io_bus.p_stat[STAT_ACC]) begin
               w_state_next = ST_DONE;
            end else if (io_bus.p_stat[STAT_ERR]) begin
               w_state_next = ST_FAIL;
               w_err_load   = 1'b1;
               w_err_val    = ERR_SYNTAX;
            end else begin
               w_state_next = ST_FETCH;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
      // A lost event makes the AST unusable, so it overrides any other outcome
      if (w_busy && w_fifo_drop) begin
         w_state_next = ST_FAIL;
         w_err_load   = 1'b1;
         w_err_val    = ERR_OVERFLOW;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_init_cnt  <= '0;
         r_wd        <= '0;
         r_tok       <= '0;
         r_p_i_valid <= 1'b0;
         r_tok_count <= '0;
         r_err_code  <= ERR_NONE;
         r_recv_d    <= 1'b0;
      end else begin
         r_recv_d <= io_bus.p_receive;
         if (w_start_job) begin
            r_init_cnt  <= '0;
            r_tok_count <= '0;
            r_err_code  <= ERR_NONE;
         end
         if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + 1'b1;
         if (w_take_tok) begin
            r_tok       <= io_bus.t_data;
            r_p_i_valid <= 1'b1;
            r_wd        <= WDW'(TIMEOUT);
         end
         if (r_state == ST_PRESENT && !io_bus.p_receive) r_wd <= r_wd - 1'b1;
         if (w_tok_recv) begin
            r_p_i_valid <= 1'b0;
            if (r_tok_count != 16'hFFFF) r_tok_count <= r_tok_count + 16'd1;
         end
         // Any abort withdraws the token from the parser
         if (w_state_next == ST_FAIL || w_state_next == ST_DONE) r_p_i_valid <= 1'b0;
         if (w_err_load) r_err_code <= w_err_val;
      end
   end

   // ---------------- event capture ----------------
   // An output right after a receive is the shift of that token; any other
   // output is a reduce driven by lookahead.
   assign w_evt = r_recv_d ? make_event(EVT_SHIFT, io_bus.p_o_shift)
                           : make_event(EVT_REDUCE, {8'h00, io_bus.p_o_reduce[7:0]});

   evt_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (EVT_DEPTH)
   ) u_evt_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (w_start_job),
      .i_push  (io_bus.p_o_valid),
      .i_data  (w_evt),
      .i_pop   (io_bus.e_ready),
      .o_data  (w_evt_head),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full),
      .o_drop  (w_fifo_drop)
   );

   // ---------------- outputs ----------------
   assign o_busy      = w_busy;
   assign o_done      = (r_state == ST_DONE);
   assign o_fail      = (r_state == ST_FAIL);
   assign o_err_code  = r_err_code;
   assign o_tok_count = r_tok_count;

   assign io_bus.t_ready   = (r_state == ST_FETCH);
   assign io_bus.p_rst     = (r_state == ST_IDLE) || (r_state == ST_INIT);
   assign io_bus.p_i_valid = r_p_i_valid;
   assign io_bus.p_i_token = r_tok;
   assign io_bus.e_valid   = !w_fifo_empty;
   assign io_bus.e_data    = w_fifo_empty ? '0 : w_evt_head;

   assign w_unused = ^{io_bus.p_o_reduce[15:8], io_bus.p_stat[STAT_RUN], w_fifo_full};

endmodule

// File: tb/tb_parse_sequencer.sv
// -----------------------------------------------------------------------------
// tb_parse_sequencer
// Directed bench: a procedural parser/lexer model drives the sequencer through
// a full accepted job, a held token, a syntax error, a timeout, an event
// overflow and a mid-job reset. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_parse_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        busy;
   logic        done;
   logic        fail;
   logic [1:0]  err_code;
   logic [15:0] tok_count;

   int          total = 0;
   int          bad   = 0;
   logic [16:0] exp_q [$];

   always #5 clk = ~clk;

   parse_sequencer_if bus();

   parse_sequencer #(
      .INIT_CYCLES (4),
      .TIMEOUT     (16),
      .EVT_DEPTH   (16)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .o_busy      (busy),
      .o_done      (done),
      .o_fail      (fail),
      .o_err_code  (err_code),
      .o_tok_count (tok_count),
      .io_bus      (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_fetch();
      int n;
      n = 0;
      while (bus.t_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check_val("fetch_wait", 32'(bus.t_ready), 32'd1);
   endtask

   // Counts sampled cycles with parser reset high, starting just after START
   task automatic check_init_len(input string tag);
      int n;
      n = 0;
      while (bus.p_rst === 1'b1 && n < 20) begin
         n++;
         tick();
      end
      check_val(tag, n, 4);
   endtask

   // One token: handshake from FETCH, rx_wait idle PRESENT cycles, receive,
   // then the CHECK cycle with the given status and optional shift output.
   task automatic do_token(input logic [15:0] tok, input int rx_wait, input logic emit_shift,
                           input logic do_reduce, input logic [7:0] rule, input logic [2:0] stat);
      int          held;
      logic [15:0] cnt0;
      held = 0;
      wait_fetch();
      cnt0 = tok_count;
      bus.t_valid = 1'b1;
      bus.t_data  = tok;
      tick();
      bus.t_valid = 1'b0;
      bus.t_data  = 16'hFFFF;
      for (int i = 0; i < rx_wait; i++) begin
         if (bus.p_i_valid && bus.p_i_token == tok && !bus.t_ready) held++;
         if (i == 0 && do_reduce) begin
            bus.p_o_valid  = 1'b1;
            bus.p_o_reduce = {8'h5A, rule};
         end
         tick();
         bus.p_o_valid = 1'b0;
      end
      if (bus.p_i_valid && bus.p_i_token == tok && !bus.t_ready) held++;
      bus.p_receive = 1'b1;
      tick();
      bus.p_receive = 1'b0;
      check_val("tok_held", held, rx_wait + 1);
      check_val("tok_inc", 32'(tok_count), 32'(cnt0) + 32'd1);
      check_val("pivalid_clr", 32'(bus.p_i_valid), 32'd0);
      bus.p_stat = stat;
      if (emit_shift) begin
         bus.p_o_valid = 1'b1;
         bus.p_o_shift = tok;
      end
      tick();
      bus.p_o_valid = 1'b0;
      bus.p_stat    = 3'b100;
      $display("token %h: held %0d cycles, tok_count=%0d", tok, held, tok_count);
   endtask

   task automatic drain_check(input string tag);
      int          got;
      int          want;
      logic [16:0] e;
      got  = 0;
      want = exp_q.size();
      while (bus.e_valid === 1'b1 && got < 40) begin
         e = (got < want) ? exp_q[got] : 17'h1FFFF;
         check_val(tag, 32'(bus.e_data), 32'(e));
         $display("event %0d popped: %h", got, bus.e_data);
         bus.e_ready = 1'b1;
         tick();
         bus.e_ready = 1'b0;
         got++;
      end
      check_val({tag, "_count"}, got, want);
      exp_q.delete();
   endtask

   initial begin
      int n;
      rst_n          = 1'b0;
      start          = 1'b0;
      bus.t_valid    = 1'b0;
      bus.t_data     = 16'h0;
      bus.p_receive  = 1'b0;
      bus.p_stat     = 3'b100;
      bus.p_o_valid  = 1'b0;
      bus.p_o_shift  = 16'h0;
      bus.p_o_reduce = 16'h0;
      bus.e_ready    = 1'b0;

      // ---- reset state ----
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_val("rst_prst", 32'(bus.p_rst), 32'd1);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done_fail", 32'({done, fail}), 32'd0);
      check_val("rst_err", 32'(err_code), 32'd0);
      check_val("rst_tokcnt", 32'(tok_count), 32'd0);
      check_val("rst_evalid", 32'(bus.e_valid), 32'd0);
      check_val("rst_tready", 32'(bus.t_ready), 32'd0);
      $display("reset checked");

      // ---- accepted job: 1 + 2 EOF ----
      pulse_start();
      check_val("job1_busy", 32'(busy), 32'd1);
      check_init_len("job1_init_len");
      do_token(16'h0101, 1, 1'b1, 1'b0, 8'h00, 3'b100);
      do_token(16'h0200, 2, 1'b1, 1'b1, 8'h03, 3'b100);
      do_token(16'h0102, 1, 1'b1, 1'b0, 8'h00, 3'b100);
      do_token(16'h0000, 2, 1'b0, 1'b1, 8'h01, 3'b110);
      check_val("job1_done", 32'(done), 32'd1);
      check_val("job1_busy_end", 32'(busy), 32'd0);
      check_val("job1_tokcnt", 32'(tok_count), 32'd4);
      check_val("job1_err", 32'(err_code), 32'd0);
      check_val("job1_prst_low", 32'(bus.p_rst), 32'd0);
      exp_q.push_back(17'h00101);
      exp_q.push_back(17'h10003);
      exp_q.push_back(17'h00200);
      exp_q.push_back(17'h00102);
      exp_q.push_back(17'h10001);
      drain_check("job1_evt");

      // ---- held token, then syntax error after token 2 ----
      pulse_start();
      check_val("job2_done_clr", 32'(done), 32'd0);
      check_init_len("job2_init_len");
      do_token(16'h0303, 6, 1'b1, 1'b0, 8'h00, 3'b100);
      check_val("job2_tokcnt1", 32'(tok_count), 32'd1);
      do_token(16'h0404, 1, 1'b1, 1'b0, 8'h00, 3'b101);
      check_val("job2_fail", 32'(fail), 32'd1);
      check_val("job2_err", 32'(err_code), 32'd1);
      check_val("job2_tokcnt2", 32'(tok_count), 32'd2);
      n = 0;
      bus.t_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (bus.t_ready) n++;
         tick();
      end
      bus.t_valid = 1'b0;
      check_val("job2_no_tready", n, 0);
      exp_q.push_back(17'h00303);
      exp_q.push_back(17'h00404);
      drain_check("job2_evt");

      // ---- watchdog timeout ----
      pulse_start();
      check_val("job3_fail_clr", 32'(fail), 32'd0);
      check_val("job3_err_clr", 32'(err_code), 32'd0);
      wait_fetch();
      bus.t_valid = 1'b1;
      bus.t_data  = 16'h0505;
      tick();
      bus.t_valid = 1'b0;
      n = 0;
      for (int g = 0; g < 40 && !fail; g++) begin
         if (bus.p_i_valid) n++;
         tick();
      end
      check_val("job3_present_len", n, 16);
      check_val("job3_fail", 32'(fail), 32'd1);
      check_val("job3_err", 32'(err_code), 32'd2);
      check_val("job3_tokcnt", 32'(tok_count), 32'd0);
      check_val("job3_pivalid", 32'(bus.p_i_valid), 32'd0);
      $display("timeout job: present %0d cycles, err=%0d", n, err_code);

      // ---- event overflow ----
      pulse_start();
      wait_fetch();
      for (int i = 0; i < 17; i++) begin
         bus.p_o_valid  = 1'b1;
         bus.p_o_reduce = {8'hFF, 8'(8'h10 + i)};
         if (i < 16) exp_q.push_back({1'b1, 8'h00, 8'(8'h10 + i)});
         tick();
         if (i == 15) check_val("job4_fail_early", 32'(fail), 32'd0);
      end
      bus.p_o_valid = 1'b0;
      check_val("job4_fail", 32'(fail), 32'd1);
      check_val("job4_err", 32'(err_code), 32'd3);
      $display("overflow job: err=%0d", err_code);
      drain_check("job4_evt");

      // ---- reset in the middle of PRESENT ----
      pulse_start();
      wait_fetch();
      bus.t_valid = 1'b1;
      bus.t_data  = 16'h0707;
      tick();
      bus.t_valid    = 1'b0;
      bus.p_o_valid  = 1'b1;
      bus.p_o_reduce = 16'h0009;
      tick();
      bus.p_o_valid = 1'b0;
      check_val("job5_pre_pivalid", 32'(bus.p_i_valid), 32'd1);
      check_val("job5_pre_evalid", 32'(bus.e_valid), 32'd1);
      rst_n = 1'b0;
      tick();
      tick();
      tick();
      check_val("job5_prst", 32'(bus.p_rst), 32'd1);
      check_val("job5_pivalid", 32'(bus.p_i_valid), 32'd0);
      check_val("job5_busy", 32'(busy), 32'd0);
      check_val("job5_evalid", 32'(bus.e_valid), 32'd0);
      check_val("job5_tokcnt", 32'(tok_count), 32'd0);
      rst_n = 1'b1;
      tick();
      check_val("job5_done_fail", 32'({done, fail}), 32'd0);
      check_val("job5_idle_prst", 32'(bus.p_rst), 32'd1);
      $display("mid-job reset checked");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
